// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, owner IDs and block-size default for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10,
    DRAIN = 2'b11
  } arb_state_t;
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;
  localparam int BLOCK_WORDS_DEF = 8;
endpackage

// File: rtl/mem_arb_txn_cnt.sv
// mem_arb_txn_cnt: transaction word counter with async reset, sync clear and increment enable
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one
//   cnt        : current count
module mem_arb_txn_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 4-cycle-latency main memory between the I-cache and the D-cache
//   Requester side : i_req/i_mem_en/i_addr -> i_grant/i_data_valid
//                    d_req/d_mem_en/d_wr/d_addr/d_wdata -> d_grant/d_data_valid
//   Memory side    : mem_enable/mem_wr/mem_addr/mem_wdata out, mem_data_valid in
//   Build option   : ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed D priority
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_mem_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_mem_en,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid
);
  localparam logic [CNT_W-1:0] BW = CNT_W'(BLOCK_WORDS);
  arb_state_t       state, state_nx;
  owner_t           owner, owner_nx;
  logic [CNT_W-1:0] issued, returned, issued_nx, returned_nx;
  logic             granted, own_d, owner_en, owner_req, store, issue, rtn, pref_d, pick_d, clr;
  assign granted   = (state == GNT_I) || (state == GNT_D);
  assign own_d     = owner == OWN_D;
  assign owner_en  = own_d ? d_mem_en : i_mem_en;
  assign owner_req = own_d ? d_req : i_req;
  assign i_grant   = state == GNT_I;
  assign d_grant   = state == GNT_D;
  // issue is capped at one block, so the counters can never wrap
  assign mem_enable = granted && owner_en && (issued < BW);
  assign store      = (state == GNT_D) && mem_enable && d_wr;
  assign mem_wr     = store;
  assign mem_wdata  = store ? d_wdata : '0;
  assign mem_addr   = (state == GNT_I) ? i_addr : (state == GNT_D) ? d_addr : '0;
  assign issue      = mem_enable && !d_wr | (mem_enable && !own_d);
  // returns are routed by the registered owner, including while draining; IDLE drops them
  assign rtn          = (state != IDLE) && mem_data_valid;
  assign i_data_valid = rtn && !own_d;
  assign d_data_valid = rtn && own_d;
  assign issued_nx    = issued + CNT_W'(issue);
  assign returned_nx  = returned + CNT_W'(rtn);
`ifdef ARB_ROUND_ROBIN_EN
  owner_t last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= OWN_I;
    else if (state == IDLE && state_nx != IDLE) last <= owner_nx;
  end
  assign pref_d = last == OWN_I;
`else
  assign pref_d = 1'b1;
`endif
  assign pick_d = d_req && (!i_req || pref_d);
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    case (state)
      IDLE: begin
        state_nx = pick_d ? GNT_D : i_req ? GNT_I : IDLE;
        owner_nx = pick_d ? OWN_D : i_req ? OWN_I : owner;
      end
      GNT_I, GNT_D:
        state_nx = (store || returned_nx == BW) ? IDLE :
                   owner_req ? state :
                   (issued_nx == returned_nx) ? IDLE : DRAIN;
      DRAIN:
        state_nx = (issued_nx == returned_nx) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  assign clr = state_nx == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_I;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end
  mem_arb_txn_cnt #(.CNT_W(CNT_W)) u_issued (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(issue), .cnt(issued)
  );
  mem_arb_txn_cnt #(.CNT_W(CNT_W)) u_returned (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(rtn), .cnt(returned)
  );
endmodule
